uart_tx_stream: RTL and testbench

- UART transmitter that drains a synchronous show-ahead FIFO.
- Sits directly downstream of the TX FIFO:
  - uses the FIFO's empty flag and its already-valid head data;
  - pops one word per frame with a single-cycle read-enable pulse.
- Serializes each word LSB-first onto the tx line, with start bit, optional parity and stop bit(s).
- Streams back-to-back frames with no idle gap while data is available.

---
 rtl/uart_tx_stream.sv | 137 +++++++++++++
 tb/tb_uart_tx_stream.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_stream.sv
// UART transmitter that drains a show-ahead FIFO: one pop per frame, LSB-first,
// optional parity, 1 or 2 stop bits, back-to-back frames while data is available.
module uart_tx_stream #(
    parameter int DATA_BITS = 8,
    parameter int BAUD_DIV  = 434,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 fifo_empty,
    input  logic [DATA_BITS-1:0] fifo_data,
    output logic                 fifo_ren,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int               CNT_W      = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST  = CNT_W'(BAUD_DIV - 1);
    localparam logic [3:0]       DATA_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST  = 4'(STOP_BITS - 1);
    localparam logic             ODD_PARITY = (PARITY == 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]           state;
    logic [CNT_W-1:0]     baud_cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 parity_bit;

    logic bit_end;
    logic last_stop;
    logic start_frame;

    // A new frame loads from IDLE or straight out of the final stop bit.
    always_comb begin
        bit_end     = (state != S_IDLE) && (baud_cnt == BAUD_LAST);
        last_stop   = (state == S_STOP) && bit_end && (bit_cnt == STOP_LAST);
        start_frame = en && !fifo_empty && ((state == S_IDLE) || last_stop);
    end

    // NOTE: shift_reg and parity_bit hold no reset; they are always loaded before use.
    always_ff @(posedge clk) begin
        if (start_frame) begin
            shift_reg  <= fifo_data;
            parity_bit <= (^fifo_data) ^ ODD_PARITY;
        end else if (bit_end && (state == S_START || state == S_DATA)) begin
            shift_reg <= shift_reg >> 1;
        end
    end

    // NOTE: non-blocking assignments throughout, so later lines in this block
    // override earlier defaults without creating ordering hazards.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            tx         <= 1'b1;
            fifo_ren   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            fifo_ren   <= 1'b0;
            frame_done <= 1'b0;

            if (state != S_IDLE) begin
                baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
            end

            case (state)
                S_IDLE: ;
                S_START: begin
                    if (bit_end) begin
                        state   <= S_DATA;
                        tx      <= shift_reg[0];
                        bit_cnt <= '0;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            if (PARITY != 0) begin
                                state <= S_PARITY;
                                tx    <= parity_bit;
                            end else begin
                                state <= S_STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                            tx      <= shift_reg[0];
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        state   <= S_STOP;
                        tx      <= 1'b1;
                        bit_cnt <= '0;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        if (bit_cnt == STOP_LAST) begin
                            frame_done <= 1'b1;
                            state      <= S_IDLE;
                            busy       <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Placed last so a back-to-back load overrides the return to IDLE.
            if (start_frame) begin
                state    <= S_START;
                tx       <= 1'b0;
                busy     <= 1'b1;
                baud_cnt <= '0;
                bit_cnt  <= '0;
                fifo_ren <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Bench for uart_tx_stream: three configurations fed from FIFO models, every tx cycle
// compared against a frame model built from the word and the framing rules.
module tb_uart_tx_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst_v = 3'b111;
    logic [2:0] en_v  = 3'b000;
    logic [2:0] empty_v, ren_v, tx_v, busy_v, done_v;
    logic [8:0] head_v [3];

    logic [8:0] mem [3][256];
    logic [7:0] wr_p [3]      = '{default: 8'd0};
    logic [7:0] rd_p [3]      = '{default: 8'd0};
    int         pops [3]      = '{default: 0};
    logic       underflow [3] = '{default: 1'b0};

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < 3; g++) begin : g_fifo
        assign empty_v[g] = (rd_p[g] == wr_p[g]);
        assign head_v[g]  = mem[g][rd_p[g]];
    end

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (ren_v[i] === 1'b1) begin
                if (rd_p[i] == wr_p[i]) underflow[i] <= 1'b1;
                else                    rd_p[i] <= rd_p[i] + 8'd1;
                pops[i] <= pops[i] + 1;
            end
        end
    end

    uart_tx_stream #(.DATA_BITS(8), .BAUD_DIV(4), .PARITY(2), .STOP_BITS(1)) u0 (
        .clk(clk), .rst(rst_v[0]), .en(en_v[0]), .fifo_empty(empty_v[0]),
        .fifo_data(head_v[0][7:0]), .fifo_ren(ren_v[0]), .tx(tx_v[0]),
        .busy(busy_v[0]), .frame_done(done_v[0]));

    uart_tx_stream #(.DATA_BITS(8), .BAUD_DIV(4), .PARITY(1), .STOP_BITS(1)) u1 (
        .clk(clk), .rst(rst_v[1]), .en(en_v[1]), .fifo_empty(empty_v[1]),
        .fifo_data(head_v[1][7:0]), .fifo_ren(ren_v[1]), .tx(tx_v[1]),
        .busy(busy_v[1]), .frame_done(done_v[1]));

    uart_tx_stream #(.DATA_BITS(7), .BAUD_DIV(2), .PARITY(0), .STOP_BITS(2)) u2 (
        .clk(clk), .rst(rst_v[2]), .en(en_v[2]), .fifo_empty(empty_v[2]),
        .fifo_data(head_v[2][6:0]), .fifo_ren(ren_v[2]), .tx(tx_v[2]),
        .busy(busy_v[2]), .frame_done(done_v[2]));

    function automatic int baud_of(input int i);
        return (i == 2) ? 2 : 4;
    endfunction

    function automatic int dbits_of(input int i);
        return (i == 2) ? 7 : 8;
    endfunction

    function automatic int par_of(input int i);
        return (i == 0) ? 2 : (i == 1) ? 1 : 0;
    endfunction

    function automatic int stops_of(input int i);
        return (i == 2) ? 2 : 1;
    endfunction

    function automatic int frame_len(input int i);
        return (1 + dbits_of(i) + ((par_of(i) != 0) ? 1 : 0) + stops_of(i)) * baud_of(i);
    endfunction

    // Expected line level for bit slot b of a frame carrying word w.
    function automatic logic exp_bit(input int i, input logic [8:0] w, input int b);
        int   d = dbits_of(i);
        logic x = 1'b0;
        if (b == 0) return 1'b0;
        if (b <= d) return w[b-1];
        if (par_of(i) != 0 && b == d + 1) begin
            for (int j = 0; j < d; j++) x ^= w[j];
            return (par_of(i) == 1) ? ~x : x;
        end
        return 1'b1;
    endfunction

    task automatic push(input int i, input logic [8:0] v);
        mem[i][wr_p[i]] = v;
        wr_p[i] = wr_p[i] + 8'd1;
    endtask

    task automatic wait_start(input int i, input int budget, input string name);
        int n = 0;
        while (tx_v[i] !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (tx_v[i] !== 1'b0) begin
            errors++;
            $display("FAIL %s start: unit %0d tx=%b after %0d cycles, expected 0", name, i, tx_v[i], budget);
        end
    endtask

    // Entered at frame offset 0; leaves at offset len, where frame_done must be high.
    task automatic check_frame(input int i, input logic [8:0] w, input int drop_k, input string name);
        int   len = frame_len(i);
        logic e;
        for (int k = 0; k < len; k++) begin
            if (k == drop_k) en_v[i] = 1'b0;
            e = exp_bit(i, w, k / baud_of(i));
            checks++;
            if (tx_v[i] !== e) begin
                errors++;
                $display("FAIL %s tx: unit %0d word %h cycle %0d got %b expected %b", name, i, w, k, tx_v[i], e);
            end
            checks++;
            if (busy_v[i] !== 1'b1) begin
                errors++;
                $display("FAIL %s busy: unit %0d cycle %0d got %b expected 1", name, i, k, busy_v[i]);
            end
            checks++;
            if (ren_v[i] !== (k == 0)) begin
                errors++;
                $display("FAIL %s fifo_ren: unit %0d cycle %0d got %b expected %b", name, i, k, ren_v[i], (k == 0));
            end
            if (k > 0) begin
                checks++;
                if (done_v[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL %s frame_done early: unit %0d cycle %0d got %b expected 0", name, i, k, done_v[i]);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (done_v[i] !== 1'b1) begin
            errors++;
            $display("FAIL %s frame_done: unit %0d got %b expected 1", name, i, done_v[i]);
        end
    endtask

    task automatic check_idle(input int i, input int n, input string name);
        for (int c = 0; c < n; c++) begin
            checks++;
            if (tx_v[i] !== 1'b1 || busy_v[i] !== 1'b0 || ren_v[i] !== 1'b0 ||
                (c > 0 && done_v[i] !== 1'b0)) begin
                errors++;
                $display("FAIL %s idle: unit %0d cycle %0d got tx=%b busy=%b ren=%b done=%b expected 1/0/0/0",
                         name, i, c, tx_v[i], busy_v[i], ren_v[i], done_v[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_v = 3'b111;
        en_v  = 3'b111;
        @(negedge clk);
        for (int c = 0; c < 22; c++) begin
            if (c == 1) rst_v = 3'b000;
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (tx_v[i] !== 1'b1 || ren_v[i] !== 1'b0 || busy_v[i] !== 1'b0 || done_v[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset/idle: unit %0d cycle %0d got tx=%b ren=%b busy=%b done=%b expected 1/0/0/0",
                             i, c, tx_v[i], ren_v[i], busy_v[i], done_v[i]);
                end
            end
            @(negedge clk);
        end
        en_v = 3'b000;
    endtask

    task automatic test_single_even();
        push(0, 9'h1A5);
        en_v[0] = 1'b1;
        wait_start(0, 4, "single_even");
        check_frame(0, 9'h1A5, -1, "single_even");
        check_idle(0, 4, "single_even");
        en_v[0] = 1'b0;
    endtask

    task automatic test_back_to_back();
        int p0 = pops[1];
        push(1, 9'h000);
        push(1, 9'h0FF);
        en_v[1] = 1'b1;
        wait_start(1, 4, "back_to_back");
        check_frame(1, 9'h000, -1, "back_to_back#1");
        check_frame(1, 9'h0FF, -1, "back_to_back#2");
        checks++;
        if (pops[1] - p0 !== 2) begin
            errors++;
            $display("FAIL back_to_back pops: got %0d expected 2", pops[1] - p0);
        end
        check_idle(1, 4, "back_to_back");
        en_v[1] = 1'b0;
    endtask

    task automatic test_en_gating();
        logic [8:0] a = 9'($urandom_range(0, 511));
        logic [8:0] b = 9'($urandom_range(0, 511));
        push(0, a);
        push(0, b);
        check_idle(0, 10, "en_low");
        en_v[0] = 1'b1;
        wait_start(0, 1, "en_rise");
        check_frame(0, a, 14, "en_drop");
        check_idle(0, 2 * frame_len(0), "en_drop");
        checks++;
        if (8'(wr_p[0] - rd_p[0]) !== 8'd1) begin
            errors++;
            $display("FAIL en_drop fifo level: got %0d expected 1", 8'(wr_p[0] - rd_p[0]));
        end
        en_v[0] = 1'b1;
        wait_start(0, 4, "en_resume");
        check_frame(0, b, -1, "en_resume");
        check_idle(0, 2, "en_resume");
        en_v[0] = 1'b0;
    endtask

    task automatic test_mid_reset();
        int         p0 = pops[0];
        logic [8:0] a  = 9'($urandom_range(0, 511));
        logic [8:0] b  = 9'($urandom_range(0, 511));
        push(0, a);
        push(0, b);
        en_v[0] = 1'b1;
        wait_start(0, 4, "mid_reset");
        repeat (13) @(negedge clk);
        rst_v[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got tx=%b busy=%b expected 1/0", tx_v[0], busy_v[0]);
        end
        rst_v[0] = 1'b0;
        wait_start(0, 4, "after_reset");
        check_frame(0, b, -1, "after_reset");
        check_idle(0, 4, "after_reset");
        checks++;
        if (pops[0] - p0 !== 2) begin
            errors++;
            $display("FAIL mid_reset pops: got %0d expected 2", pops[0] - p0);
        end
        en_v[0] = 1'b0;
    endtask

    task automatic test_two_stop();
        push(2, 9'h1C1);
        en_v[2] = 1'b1;
        wait_start(2, 4, "two_stop");
        check_frame(2, 9'h1C1, -1, "two_stop");
        check_idle(2, 4, "two_stop");
        en_v[2] = 1'b0;
    endtask

    task automatic test_random();
        logic [8:0] ws [5];
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 5; j++) begin
                ws[j] = 9'($urandom_range(0, 511));
                push(i, ws[j]);
            end
            en_v[i] = 1'b1;
            wait_start(i, 4, "random");
            for (int j = 0; j < 5; j++) check_frame(i, ws[j], -1, "random");
            check_idle(i, 3, "random");
            en_v[i] = 1'b0;
        end
    endtask

    task automatic test_no_underflow();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (underflow[i] !== 1'b0) begin
                errors++;
                $display("FAIL underflow: unit %0d popped an empty FIFO", i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_even();
        test_back_to_back();
        test_en_gating();
        test_mid_reset();
        test_two_stop();
        test_random();
        test_no_underflow();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
